// File: rtl/weight_fetch_scheduler.sv
// Credit-limited (od pair, id) weight fetch sequencer for the Winograd weight path.
// Optional stall counter enabled by defining WEIGHT_SCHED_PERF_EN.
module weight_fetch_scheduler #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int OD_W            = 8,
  parameter int ID_W            = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [OD_W-1:0] total_od_i,
  input  logic [ID_W-1:0] total_id_i,
  input  logic            pe_ready_i,
  output logic [OD_W-1:0] weight_od1_o,
  output logic [ID_W-1:0] weight_id_o,
  output logic            weight_main_valid_o,
  output logic            pkg2_mask_o,
  input  logic            ret_valid_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [1:0]      dbg_state_o,
`ifdef WEIGHT_SCHED_PERF_EN
  output logic [15:0]     stall_cnt_o,
`endif
  output logic            cfg_err_o
);

  // Handshake: a fetch is issued in any ISSUE cycle where pe_ready_i=1 and a
  // credit is free; weight_main_valid_o is that issue strobe and is not held.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  localparam int            PW       = OD_W + ID_W;
  localparam logic [2:0]    CRED_MAX = 3'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] ADDR_LIM = PW'(1) << OD_W;

  state_e          state_q;
  logic [2:0]      credits_q, credits_d;
  logic [OD_W-1:0] od_cnt_q, od_hold_q, tot_od_q;
  logic [ID_W-1:0] id_cnt_q, id_hold_q, tot_id_q;
  logic            cfg_err_q;
  logic            issue, od_wrap, last_issue, cfg_bad;
  logic [PW-1:0]   prod;
`ifdef WEIGHT_SCHED_PERF_EN
  logic [15:0]     stall_q;
`endif

  always_comb begin
    issue      = (state_q == S_ISSUE) && pe_ready_i && (credits_q != 3'd0);
    od_wrap    = ({1'b0, od_cnt_q} + (OD_W+1)'(2)) >= {1'b0, tot_od_q};
    last_issue = issue && od_wrap && (id_cnt_q == tot_id_q - ID_W'(1));
    prod       = PW'(total_od_i) * PW'(total_id_i);
    cfg_bad    = (total_od_i == '0) || (total_id_i == '0) || (prod > ADDR_LIM);
    // A return with no fetch outstanding is a stray (e.g. after reset) and is dropped.
    credits_d = credits_q;
    if (issue && !ret_valid_i)
      credits_d = credits_q - 3'd1;
    else if (!issue && ret_valid_i && (credits_q != CRED_MAX))
      credits_d = credits_q + 3'd1;
  end

  assign weight_main_valid_o = issue;
  assign weight_od1_o        = issue ? od_cnt_q : od_hold_q;
  assign weight_id_o         = issue ? id_cnt_q : id_hold_q;
  assign pkg2_mask_o         = issue && (({1'b0, od_cnt_q} + (OD_W+1)'(1)) >= {1'b0, tot_od_q});
  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = (state_q == S_DONE);
  assign cfg_err_o           = cfg_err_q;
  assign dbg_state_o         = state_q;
`ifdef WEIGHT_SCHED_PERF_EN
  assign stall_cnt_o         = stall_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      credits_q <= CRED_MAX;
      od_cnt_q  <= '0;
      id_cnt_q  <= '0;
      od_hold_q <= '0;
      id_hold_q <= '0;
      tot_od_q  <= '0;
      tot_id_q  <= '0;
      cfg_err_q <= 1'b0;
`ifdef WEIGHT_SCHED_PERF_EN
      stall_q   <= '0;
`endif
    end else begin
      credits_q <= credits_d;
      if (issue) begin
        od_hold_q <= od_cnt_q;
        id_hold_q <= id_cnt_q;
        if (od_wrap) begin
          od_cnt_q <= '0;
          id_cnt_q <= id_cnt_q + ID_W'(1);
        end else begin
          od_cnt_q <= od_cnt_q + OD_W'(2);
        end
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b0;
              tot_od_q  <= total_od_i;
              tot_id_q  <= total_id_i;
              od_cnt_q  <= '0;
              id_cnt_q  <= '0;
              state_q   <= S_ISSUE;
`ifdef WEIGHT_SCHED_PERF_EN
              stall_q   <= '0;
`endif
            end
          end
        end
        S_ISSUE: begin
`ifdef WEIGHT_SCHED_PERF_EN
          if ((!pe_ready_i || (credits_q == 3'd0)) && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
`endif
          if (last_issue) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Looking at credits_d lets the final return and DRAIN exit share a cycle.
          if (credits_d == CRED_MAX) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// Self-checking bench for weight_fetch_scheduler: directed passes plus random
// passes compared against a pass-level model (expected issue list + credit count).
module tb_weight_fetch_scheduler;
  localparam int MAX  = 2;
  localparam int OD_W = 8;
  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start_i = 1'b0;
  logic [OD_W-1:0] total_od_i = '0;
  logic [ID_W-1:0] total_id_i = '0;
  logic            pe_ready_i = 1'b0;
  logic            ret_valid_i = 1'b0;
  logic [OD_W-1:0] weight_od1_o;
  logic [ID_W-1:0] weight_id_o;
  logic            weight_main_valid_o, pkg2_mask_o, busy_o, done_o, cfg_err_o;
  logic [1:0]      dbg_state_o;
`ifdef WEIGHT_SCHED_PERF_EN
  logic [15:0]     stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_fetch_scheduler #(.MAX_OUTSTANDING(MAX), .OD_W(OD_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i),
    .total_od_i(total_od_i), .total_id_i(total_id_i), .pe_ready_i(pe_ready_i),
    .weight_od1_o(weight_od1_o), .weight_id_o(weight_id_o),
    .weight_main_valid_o(weight_main_valid_o), .pkg2_mask_o(pkg2_mask_o),
    .ret_valid_i(ret_valid_i), .busy_o(busy_o), .done_o(done_o),
    .dbg_state_o(dbg_state_o),
`ifdef WEIGHT_SCHED_PERF_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .cfg_err_o(cfg_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0,1 repeating.
  // Each fetch is returned dmin..dmax cycles after issue, one return per cycle.
  task automatic run_pass(input int tod, input int tid, input int rmode,
                          input int dmin, input int dmax);
    int eod_q[$], eid_q[$], emk_q[$], due_q[$];
    int cyc, outst, phase, stalls, d;
    bit rdy, rt, vexp;
    int pat[4] = '{1, 0, 0, 1};
    for (int i = 0; i < tid; i++)
      for (int o = 0; o < tod; o += 2) begin
        eod_q.push_back(o);
        eid_q.push_back(i);
        emk_q.push_back((o + 1 >= tod) ? 1 : 0);
      end
    start_i = 1'b1; total_od_i = OD_W'(tod); total_id_i = ID_W'(tid);
    pe_ready_i = 1'b0; ret_valid_i = 1'b0;
    @(negedge clk);
    chk("start_cycle_valid", 32'(weight_main_valid_o), 0);
    next_cycle();
    start_i = 1'b0;
    cyc = 1; outst = 0; phase = 0; stalls = 0;
    while (phase != 3 && cyc < 3000) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = pat[(cyc - 1) % 4] != 0;
      endcase
      rt = (due_q.size() > 0) && (due_q[0] <= cyc);
      if (rt) void'(due_q.pop_front());
      pe_ready_i = rdy; ret_valid_i = rt;
      @(negedge clk);
      vexp = (phase == 0) && rdy && (outst < MAX);
      chk("main_valid", 32'(weight_main_valid_o), 32'(vexp));
      chk("busy", 32'(busy_o), 1);
      chk("done", 32'(done_o), 32'(phase == 2));
      chk("cfg_err_clear", 32'(cfg_err_o), 0);
      if (vexp && eod_q.size() > 0) begin
        chk("od1", 32'(weight_od1_o), 32'(eod_q.pop_front()));
        chk("id", 32'(weight_id_o), 32'(eid_q.pop_front()));
        chk("pkg2_mask", 32'(pkg2_mask_o), 32'(emk_q.pop_front()));
        d = $urandom_range(dmin, dmax);
        due_q.push_back(cyc + d);
      end
      if (phase == 0 && !vexp) stalls++;
`ifdef WEIGHT_SCHED_PERF_EN
      if (phase == 2) chk("stall_cnt", 32'(stall_cnt_o), 32'(stalls));
`endif
      outst = outst + (vexp ? 1 : 0) - (rt ? 1 : 0);
      if (phase == 2) phase = 3;
      else if (phase == 1 && outst == 0) phase = 2;
      else if (phase == 0 && vexp && eod_q.size() == 0) phase = 1;
      next_cycle();
      cyc++;
    end
    pe_ready_i = 1'b0; ret_valid_i = 1'b0;
    if (phase != 3) chk("pass_timeout", 32'(phase), 3);
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_done", 32'(done_o), 0);
    next_cycle();
  endtask

  task automatic bad_start(input int tod, input int tid);
    start_i = 1'b1; total_od_i = OD_W'(tod); total_id_i = ID_W'(tid); pe_ready_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    @(negedge clk);
    chk("bad_busy", 32'(busy_o), 0);
    chk("bad_valid", 32'(weight_main_valid_o), 0);
    chk("bad_cfg_err", 32'(cfg_err_o), 1);
    next_cycle();
    pe_ready_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(weight_main_valid_o), 0);
    chk({tag, "_od1"}, 32'(weight_od1_o), 0);
    chk({tag, "_id"}, 32'(weight_id_o), 0);
    chk({tag, "_mask"}, 32'(pkg2_mask_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_cfg_err"}, 32'(cfg_err_o), 0);
  endtask

  initial begin
    int tod, tid;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    next_cycle();

    run_pass(4, 2, 0, 1, 1);
    run_pass(5, 1, 0, 1, 1);
    run_pass(6, 1, 0, 8, 8);
    run_pass(8, 2, 0, 2, 2);
    run_pass(4, 1, 2, 1, 1);
    run_pass(7, 3, 2, 1, 3);

    bad_start(200, 2);
    bad_start(0, 3);
    bad_start(9, 0);
    run_pass(128, 2, 0, 1, 2);
    run_pass(255, 1, 1, 1, 4);
    run_pass(1, 1, 0, 1, 1);

    // Two fetches issued, one returned, then reset with one still outstanding.
    start_i = 1'b1; total_od_i = 8'd8; total_id_i = 4'd2;
    next_cycle();
    start_i = 1'b0; pe_ready_i = 1'b1;
    next_cycle();
    next_cycle();
    pe_ready_i = 1'b0; ret_valid_i = 1'b1;
    @(negedge clk);
    chk("pre_reset_od1_hold", 32'(weight_od1_o), 2);
    next_cycle();
    ret_valid_i = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    reset_n = 1'b1;
    next_cycle();
    ret_valid_i = 1'b1;
    next_cycle();
    ret_valid_i = 1'b0;
    @(negedge clk);
    chk("stray_ret_busy", 32'(busy_o), 0);
    next_cycle();
    run_pass(6, 2, 0, 8, 8);

    for (int p = 0; p < 8; p++) begin
      tid = $urandom_range(1, 6);
      tod = $urandom_range(1, 40);
      run_pass(tod, tid, 1, 1, 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
